// File: rtl/axi2ahb_wdata.sv
// AXI-to-AHB bridge write path: buffers W beats, drives HWDATA/HWSTRB
// in controller-scheduled data phases and returns the AXI B response.
module axi2ahb_wdata #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                        WLAST,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [AXI_DATA_WIDTH-1:0]   HWDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                        HREADY,
  input  logic                        HRESP,
  input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
  input  logic                        ctrl_wdata_ready,
  output logic                        ctrl_wdata_valid,
  output logic                        ctrl_wdata_last
);

  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AXI_DATA_WIDTH + SW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    LAST_DP,
    RESP
  } state_e;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic          dp_q, dp_d;
  logic          err_q, err_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [AXI_DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [SW-1:0]             hwstrb_q, hwstrb_d;

  logic          full, empty, push, pop, done, head_last;
  logic [EW-1:0] head;

  assign head      = mem_q[rptr_q];
  assign head_last = head[0];
  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);

  // No pop-through: a full FIFO refuses W even while popping.
  assign WREADY = ARESETN && !full;
  assign push   = WVALID && WREADY;
  assign pop    = ctrl_wdata_ready && ctrl_wdata_valid;
  assign done   = dp_q && HREADY;

  assign ctrl_wdata_valid = !empty &&
    (state_q == IDLE || state_q == BURST);
  assign ctrl_wdata_last  = ctrl_wdata_valid && head_last;

  assign BVALID = (state_q == RESP);
  assign BID    = bid_q;
  assign BRESP  = bresp_q;
  assign HWDATA = hwdata_q;
  assign HWSTRB = hwstrb_q;

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wptr_q] <= {WDATA, WSTRB, WLAST};
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    dp_d     = dp_q;
    err_d    = err_q;
    hwdata_d = hwdata_q;
    hwstrb_d = hwstrb_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop) begin
      rptr_d   = rptr_q + PW'(1);
      hwdata_d = head[EW-1 -: AXI_DATA_WIDTH];
      hwstrb_d = head[SW:1];
      dp_d     = 1'b1;
    end else if (done) begin
      dp_d = 1'b0;
    end
    if (done && HRESP) err_d = 1'b1;
    if (BVALID && BREADY) err_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          bid_d   = cmd_id;
          state_d = head_last ? LAST_DP : BURST;
        end
      end
      BURST: begin
        if (pop && head_last) state_d = LAST_DP;
      end
      LAST_DP: begin
        if (done) begin
          state_d = RESP;
          bresp_d = (err_q || HRESP) ? 2'b10 : 2'b00;
        end
      end
      RESP: begin
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      dp_q     <= 1'b0;
      err_q    <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= 2'b00;
      hwdata_q <= '0;
      hwstrb_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      hwdata_q <= hwdata_d;
      hwstrb_q <= hwstrb_d;
    end
  end

endmodule

// File: tb/tb_axi2ahb_wdata.sv
// Directed bench for axi2ahb_wdata: acts as AXI master, AHB slave
// and bridge controller, checking hand-computed values per cycle.
module tb_axi2ahb_wdata;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [0:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        HREADY;
  logic        HRESP;
  logic [0:0]  cmd_id;
  logic        ctrl_wdata_ready;
  logic        ctrl_wdata_valid;
  logic        ctrl_wdata_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ACLK = ~ACLK;

  axi2ahb_wdata #(
    .AXI_ID_WIDTH(1),
    .AXI_DATA_WIDTH(32),
    .FIFO_DEPTH(2)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .WDATA(WDATA),
    .WSTRB(WSTRB),
    .WLAST(WLAST),
    .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID),
    .BRESP(BRESP),
    .BVALID(BVALID),
    .BREADY(BREADY),
    .HWDATA(HWDATA),
    .HWSTRB(HWSTRB),
    .HREADY(HREADY),
    .HRESP(HRESP),
    .cmd_id(cmd_id),
    .ctrl_wdata_ready(ctrl_wdata_ready),
    .ctrl_wdata_valid(ctrl_wdata_valid),
    .ctrl_wdata_last(ctrl_wdata_last)
  );

  // Controller may only pop a scheduled beat while HREADY is high.
  always @(posedge ACLK) begin
    if (ARESETN === 1'b1 && ctrl_wdata_ready === 1'b1) begin
      n_cmp++;
      assert (HREADY === 1'b1 && ctrl_wdata_valid === 1'b1)
      else begin
        n_bad++;
        $display("FAIL pop_legal got hready=%b valid=%b want 1 1",
                 HREADY, ctrl_wdata_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s,
                           input logic l);
    int k;
    WDATA  = d;
    WSTRB  = s;
    WLAST  = l;
    WVALID = 1'b1;
    k = 0;
    while (WREADY !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (k == 20) begin
      n_cmp++; n_bad++;
      $display("FAIL push_wait got wready=%b want 1", WREADY);
    end
    step();
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic pop_beat;
    int k;
    HREADY = 1'b1;
    k = 0;
    while (ctrl_wdata_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (k == 20) begin
      n_cmp++; n_bad++;
      $display("FAIL pop_wait got valid=%b want 1", ctrl_wdata_valid);
    end else begin
      ctrl_wdata_ready = 1'b1;
      step();
      ctrl_wdata_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    step();
    step();
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL rst_wready got %b want 0", WREADY); end
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL rst_bvalid got %b want 0", BVALID); end
    n_cmp++; if (BRESP !== 2'b00) begin n_bad++; $display("FAIL rst_bresp got %b want 00", BRESP); end
    n_cmp++; if (BID !== 1'b0) begin n_bad++; $display("FAIL rst_bid got %b want 0", BID); end
    n_cmp++; if (HWDATA !== 32'h0) begin n_bad++; $display("FAIL rst_hwdata got %h want 0", HWDATA); end
    n_cmp++; if (HWSTRB !== 4'h0) begin n_bad++; $display("FAIL rst_hwstrb got %h want 0", HWSTRB); end
    n_cmp++; if (ctrl_wdata_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cvalid got %b want 0", ctrl_wdata_valid); end
    n_cmp++; if (ctrl_wdata_last !== 1'b0) begin n_bad++; $display("FAIL rst_clast got %b want 0", ctrl_wdata_last); end
    ARESETN = 1'b1;
    #1;
    n_cmp++; if (WREADY !== 1'b1) begin n_bad++; $display("FAIL rst_wready_rel got %b want 1", WREADY); end
    step();
  endtask

  task automatic test_single;
    cmd_id = 1'b1;
    push_beat(32'hA5A5_0001, 4'hF, 1'b1);
    n_cmp++; if (ctrl_wdata_valid !== 1'b1) begin n_bad++; $display("FAIL sgl_cvalid got %b want 1", ctrl_wdata_valid); end
    n_cmp++; if (ctrl_wdata_last !== 1'b1) begin n_bad++; $display("FAIL sgl_clast got %b want 1", ctrl_wdata_last); end
    HREADY = 1'b1;
    ctrl_wdata_ready = 1'b1;
    step();
    ctrl_wdata_ready = 1'b0;
    n_cmp++; if (HWDATA !== 32'hA5A5_0001) begin n_bad++; $display("FAIL sgl_hwdata got %h want a5a50001", HWDATA); end
    n_cmp++; if (HWSTRB !== 4'hF) begin n_bad++; $display("FAIL sgl_hwstrb got %h want f", HWSTRB); end
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL sgl_bvalid_early got %b want 0", BVALID); end
    step();
    n_cmp++; if (BVALID !== 1'b1) begin n_bad++; $display("FAIL sgl_bvalid got %b want 1", BVALID); end
    n_cmp++; if (BRESP !== 2'b00) begin n_bad++; $display("FAIL sgl_bresp got %b want 00", BRESP); end
    n_cmp++; if (BID !== 1'b1) begin n_bad++; $display("FAIL sgl_bid got %b want 1", BID); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL sgl_bvalid_done got %b want 0", BVALID); end
    n_cmp++; if (HWDATA !== 32'hA5A5_0001) begin n_bad++; $display("FAIL sgl_hold got %h want a5a50001", HWDATA); end
  endtask

  task automatic test_burst4;
    cmd_id = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    push_beat(32'h10, 4'hF, 1'b0);
    push_beat(32'h11, 4'hF, 1'b0);
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL b4_full got %b want 0", WREADY); end
    ctrl_wdata_ready = 1'b1;
    step();
    n_cmp++; if (HWDATA !== 32'h10) begin n_bad++; $display("FAIL b4_d0 got %h want 10", HWDATA); end
    WDATA = 32'h12; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    step();
    n_cmp++; if (HWDATA !== 32'h11) begin n_bad++; $display("FAIL b4_d1 got %h want 11", HWDATA); end
    ctrl_wdata_ready = 1'b0;
    HREADY = 1'b0;
    WDATA = 32'h13; WLAST = 1'b1;
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    n_cmp++; if (HWDATA !== 32'h11) begin n_bad++; $display("FAIL b4_d1_wait1 got %h want 11", HWDATA); end
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL b4_full2 got %b want 0", WREADY); end
    step();
    n_cmp++; if (HWDATA !== 32'h11) begin n_bad++; $display("FAIL b4_d1_wait2 got %h want 11", HWDATA); end
    HREADY = 1'b1;
    ctrl_wdata_ready = 1'b1;
    step();
    n_cmp++; if (HWDATA !== 32'h12) begin n_bad++; $display("FAIL b4_d2 got %h want 12", HWDATA); end
    n_cmp++; if (ctrl_wdata_last !== 1'b1) begin n_bad++; $display("FAIL b4_clast got %b want 1", ctrl_wdata_last); end
    step();
    ctrl_wdata_ready = 1'b0;
    n_cmp++; if (HWDATA !== 32'h13) begin n_bad++; $display("FAIL b4_d3 got %h want 13", HWDATA); end
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL b4_bvalid_early got %b want 0", BVALID); end
    n_cmp++; if (ctrl_wdata_valid !== 1'b0) begin n_bad++; $display("FAIL b4_cvalid got %b want 0", ctrl_wdata_valid); end
    step();
    n_cmp++; if (BVALID !== 1'b1) begin n_bad++; $display("FAIL b4_bvalid got %b want 1", BVALID); end
    n_cmp++; if (BRESP !== 2'b00) begin n_bad++; $display("FAIL b4_bresp got %b want 00", BRESP); end
    n_cmp++; if (BID !== 1'b0) begin n_bad++; $display("FAIL b4_bid got %b want 0", BID); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL b4_bvalid_done got %b want 0", BVALID); end
    step();
    step();
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL b4_one_b got %b want 0", BVALID); end
  endtask

  task automatic test_error;
    cmd_id = 1'b1;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    push_beat(32'h20, 4'h3, 1'b0);
    push_beat(32'h21, 4'hC, 1'b0);
    ctrl_wdata_ready = 1'b1;
    step();
    n_cmp++; if (HWDATA !== 32'h20 || HWSTRB !== 4'h3) begin n_bad++; $display("FAIL err_d0 got %h/%h want 20/3", HWDATA, HWSTRB); end
    WDATA = 32'h22; WSTRB = 4'h5; WLAST = 1'b1; WVALID = 1'b1;
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    n_cmp++; if (HWDATA !== 32'h21 || HWSTRB !== 4'hC) begin n_bad++; $display("FAIL err_d1 got %h/%h want 21/c", HWDATA, HWSTRB); end
    HRESP = 1'b1;
    step();
    HRESP = 1'b0;
    ctrl_wdata_ready = 1'b0;
    n_cmp++; if (HWDATA !== 32'h22 || HWSTRB !== 4'h5) begin n_bad++; $display("FAIL err_d2 got %h/%h want 22/5", HWDATA, HWSTRB); end
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL err_bvalid_early got %b want 0", BVALID); end
    step();
    n_cmp++; if (BVALID !== 1'b1) begin n_bad++; $display("FAIL err_bvalid got %b want 1", BVALID); end
    n_cmp++; if (BRESP !== 2'b10) begin n_bad++; $display("FAIL err_bresp got %b want 10", BRESP); end
    n_cmp++; if (BID !== 1'b1) begin n_bad++; $display("FAIL err_bid got %b want 1", BID); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    cmd_id = 1'b0;
    push_beat(32'h30, 4'hF, 1'b1);
    pop_beat();
    n_cmp++; if (HWDATA !== 32'h30) begin n_bad++; $display("FAIL err_next_d got %h want 30", HWDATA); end
    step();
    n_cmp++; if (BVALID !== 1'b1) begin n_bad++; $display("FAIL err_next_bvalid got %b want 1", BVALID); end
    n_cmp++; if (BRESP !== 2'b00) begin n_bad++; $display("FAIL err_next_bresp got %b want 00", BRESP); end
    n_cmp++; if (BID !== 1'b0) begin n_bad++; $display("FAIL err_next_bid got %b want 0", BID); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    push_beat(32'h31, 4'hF, 1'b1);
    pop_beat();
    HRESP = 1'b1;
    step();
    HRESP = 1'b0;
    n_cmp++; if (BRESP !== 2'b10) begin n_bad++; $display("FAIL err_last_bresp got %b want 10", BRESP); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
  endtask

  task automatic test_full;
    cmd_id = 1'b1;
    HREADY = 1'b1;
    WVALID = 1'b1; WSTRB = 4'hF; WLAST = 1'b0;
    WDATA = 32'h40;
    n_cmp++; if (WREADY !== 1'b1) begin n_bad++; $display("FAIL full_acc0 got %b want 1", WREADY); end
    step();
    WDATA = 32'h41;
    n_cmp++; if (WREADY !== 1'b1) begin n_bad++; $display("FAIL full_acc1 got %b want 1", WREADY); end
    step();
    WDATA = 32'h42; WLAST = 1'b1;
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL full_stall got %b want 0", WREADY); end
    step();
    ctrl_wdata_ready = 1'b1;
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL full_no_popthru got %b want 0", WREADY); end
    step();
    ctrl_wdata_ready = 1'b0;
    n_cmp++; if (WREADY !== 1'b1) begin n_bad++; $display("FAIL full_reopen got %b want 1", WREADY); end
    n_cmp++; if (HWDATA !== 32'h40) begin n_bad++; $display("FAIL full_d0 got %h want 40", HWDATA); end
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    pop_beat();
    n_cmp++; if (HWDATA !== 32'h41) begin n_bad++; $display("FAIL full_d1 got %h want 41", HWDATA); end
    pop_beat();
    n_cmp++; if (HWDATA !== 32'h42) begin n_bad++; $display("FAIL full_d2 got %h want 42", HWDATA); end
    step();
    n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b00 || BID !== 1'b1) begin n_bad++; $display("FAIL full_b got %b/%b/%b want 1/00/1", BVALID, BRESP, BID); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
  endtask

  task automatic test_bready_hold;
    cmd_id = 1'b1;
    HREADY = 1'b1;
    push_beat(32'h50, 4'hF, 1'b1);
    push_beat(32'h60, 4'hF, 1'b1);
    pop_beat();
    step();
    cmd_id = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (BVALID !== 1'b1 || BID !== 1'b1 || BRESP !== 2'b00) begin n_bad++; $display("FAIL hold_b%0d got %b/%b/%b want 1/1/00", i, BVALID, BID, BRESP); end
      n_cmp++; if (ctrl_wdata_valid !== 1'b0) begin n_bad++; $display("FAIL hold_cvalid%0d got %b want 0", i, ctrl_wdata_valid); end
      step();
    end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL hold_bdone got %b want 0", BVALID); end
    n_cmp++; if (ctrl_wdata_valid !== 1'b1) begin n_bad++; $display("FAIL hold_cvalid_next got %b want 1", ctrl_wdata_valid); end
    pop_beat();
    n_cmp++; if (HWDATA !== 32'h60) begin n_bad++; $display("FAIL hold_d got %h want 60", HWDATA); end
    step();
    n_cmp++; if (BVALID !== 1'b1 || BID !== 1'b0) begin n_bad++; $display("FAIL hold_b2 got %b/%b want 1/0", BVALID, BID); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
  endtask

  task automatic test_reset_mid;
    cmd_id = 1'b1;
    HREADY = 1'b1;
    push_beat(32'h70, 4'h7, 1'b0);
    push_beat(32'h71, 4'h7, 1'b0);
    pop_beat();
    push_beat(32'h72, 4'h7, 1'b0);
    pop_beat();
    ARESETN = 1'b0;
    #1;
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL mid_wready_lo got %b want 0", WREADY); end
    step();
    ARESETN = 1'b1;
    #1;
    n_cmp++; if (HWDATA !== 32'h0 || HWSTRB !== 4'h0) begin n_bad++; $display("FAIL mid_hw got %h/%h want 0/0", HWDATA, HWSTRB); end
    n_cmp++; if (BVALID !== 1'b0 || BID !== 1'b0 || BRESP !== 2'b00) begin n_bad++; $display("FAIL mid_b got %b/%b/%b want 0/0/00", BVALID, BID, BRESP); end
    n_cmp++; if (ctrl_wdata_valid !== 1'b0 || ctrl_wdata_last !== 1'b0) begin n_bad++; $display("FAIL mid_ctrl got %b/%b want 0/0", ctrl_wdata_valid, ctrl_wdata_last); end
    n_cmp++; if (WREADY !== 1'b1) begin n_bad++; $display("FAIL mid_wready got %b want 1", WREADY); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL mid_no_b%0d got %b want 0", i, BVALID); end
    end
    push_beat(32'h80, 4'hF, 1'b1);
    pop_beat();
    n_cmp++; if (HWDATA !== 32'h80) begin n_bad++; $display("FAIL mid_fresh_d got %h want 80", HWDATA); end
    step();
    n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b00 || BID !== 1'b1) begin n_bad++; $display("FAIL mid_fresh_b got %b/%b/%b want 1/00/1", BVALID, BRESP, BID); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    cmd_id = '0; ctrl_wdata_ready = 1'b0;
    test_reset();
    test_single();
    test_burst4();
    test_error();
    test_full();
    test_bready_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi2ahb_wdata.md
# axi2ahb_wdata

Write-data and write-response path of the AXI-to-AHB bridge. Accepts AXI W beats into a small FIFO and drives HWDATA/HWSTRB in AHB data phases that the bridge controller schedules. After the last beat's data phase completes, it returns the AXI B response, with an error if any beat received HRESP. It is the write-direction counterpart of the read-data path and shares the controller's cmd/ctrl handshake style.

## Interface
- AXI_ID_WIDTH, 1, width of BID and cmd_id
- AXI_DATA_WIDTH, 32, data width; strobe width is AXI_DATA_WIDTH/8
- FIFO_DEPTH, 2, W-beat buffer entries; power of two, at least 2

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  synchronous active-low reset
- WDATA  in  AXI_DATA_WIDTH  AXI write data
- WSTRB  in  AXI_DATA_WIDTH/8  AXI byte strobes
- WLAST  in  1  last beat of burst
- WVALID  in  1  W beat valid
- WREADY  out  1  W beat accepted when WVALID&&WREADY
- BID  out  AXI_ID_WIDTH  response ID
- BRESP  out  2  2'b00 OKAY or 2'b10 SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  response accepted
- HWDATA  out  AXI_DATA_WIDTH  AHB write data, registered
- HWSTRB  out  AXI_DATA_WIDTH/8  AHB byte strobes, registered
- HREADY  in  1  AHB transfer-done
- HRESP  in  1  AHB error response
- cmd_id  in  AXI_ID_WIDTH  ID of the current write command, stable while the burst is in flight
- ctrl_wdata_ready  in  1  pulse: controller's write address phase accepted this cycle; pop head beat
- ctrl_wdata_valid  out  1  a beat is available and may be scheduled
- ctrl_wdata_last  out  1  head beat carries WLAST; valid when ctrl_wdata_valid

## Operation
- FIFO entry = {WDATA, WSTRB, WLAST}. Push on WVALID&&WREADY.
- WREADY = !full. There is no pop-through: when the FIFO is full, WREADY stays low even if a pop occurs in the same cycle.
- Pop on ctrl_wdata_ready. At that edge, HWDATA/HWSTRB load the head entry and dp_active sets.
- ctrl_wdata_ready is only legal with HREADY=1 and ctrl_wdata_valid=1; the bench asserts on any violation.
- Data-phase completion = dp_active && HREADY. A pop in the same cycle is the pipelined next beat.
- On completion with no pop, dp_active clears. HWDATA/HWSTRB hold their last value.
- err_sticky sets when completion occurs with HRESP=1. It clears when the B handshake completes.
- FSM states:
  - IDLE: on pop, capture cmd_id into BID and go to BURST. If the popped beat has WLAST, go to LAST_DP instead.
  - BURST: on a pop with WLAST, go to LAST_DP.
  - LAST_DP: on completion, go to RESP. BVALID=1 next cycle, BRESP = (err_sticky or HRESP at completion) ? 2'b10 : 2'b00.
  - RESP: hold BID/BRESP/BVALID until BREADY, then go to IDLE.
- ctrl_wdata_valid = !empty && state is IDLE or BURST. No beat of the next burst is scheduled until B is accepted.
- A burst ends only on WLAST; beat count is not checked here.

## Timing
- Reset (ARESETN=0 at edge): FIFO empty, state IDLE, dp_active=0, err_sticky=0.
- Output values after reset: WREADY=0 while ARESETN low, then 1. BVALID=0, BRESP=0, BID=0, HWDATA=0, HWSTRB=0, ctrl_wdata_valid=0, ctrl_wdata_last=0.
- Reset mid-burst discards FIFO contents and any pending response. No B is issued.
- W accept to ctrl_wdata_valid: 1 cycle (registered FIFO count).
- Pop to HWDATA valid: the cycle after the pop edge, i.e. the AHB data phase.
- Last data-phase completion to BVALID: 1 cycle.
- BVALID handshake to the next burst's ctrl_wdata_valid: 1 cycle.
- Push and pop in the same cycle: count unchanged and pointers both advance. Pointers wrap modulo FIFO_DEPTH.
- HREADY=0 stretches the data phase. HWDATA/HWSTRB must stay stable for the whole stretch.

## Test plan
- Single beat (WDATA=32'hA5A5_0001, WSTRB=4'hF, WLAST=1), pop with HREADY=1 throughout -> HWDATA=32'hA5A5_0001 for 1 cycle, BVALID 1 cycle after completion, BRESP=0, BID=cmd_id.
- 4-beat burst 0x10..0x13, HREADY low for 2 cycles on beat 1 -> each HWDATA held until its completion, values in order, exactly one B with OKAY.
- 3-beat burst with HRESP=1 at completion of beat 2 -> all 3 beats still drive HWDATA, BRESP=2'b10; the following burst returns OKAY.
- FIFO_DEPTH=2 with no pops and WVALID held high -> WREADY falls after 2 accepts. One pop -> WREADY returns next cycle and the third beat is accepted.
- BREADY held low for 5 cycles with a second burst buffered -> BVALID/BID/BRESP stable, ctrl_wdata_valid=0 until B accepted, then 1 next cycle.
- ARESETN low for 1 cycle after the 2nd beat of a 4-beat burst -> all outputs at reset values, no BVALID; a fresh single-beat burst then completes normally.
